// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryption core: one inverse round per clock, start/busy/done handshake.
// Consumes the same 1408-bit expanded key schedule as the encryption datapath.

module aes_inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  // NOTE: a constant lookup table is pure combinational logic; it needs no reset.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign o_y = INV_SBOX[i_a];
endmodule

module aes_decrypt_iterative (
  input  logic           clk,
  input  logic           rst,
  input  logic [1407:0]  key,
  input  logic           start,
  input  logic [127:0]   cipher_data,
  output logic           busy,
  output logic           done,
  output logic [127:0]   plain_data
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  logic [1:0]   r_fsm;
  logic [3:0]   r_cnt;
  logic [127:0] r_state;
  logic [127:0] r_plain;
  logic         r_busy;
  logic         r_done;

  logic [127:0] w_isr;
  logic [127:0] w_isb;
  logic [127:0] w_rk;
  logic [127:0] w_ark;
  logic [127:0] w_imc;
  logic [127:0] w_rk10;
  logic [127:0] w_rk_arr [16];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ {3'b000, b[7], b[7], 1'b0, b[7], b[7]};
  endfunction

  // m selects which of b, 2b, 4b, 8b are summed; covers 0x09/0x0b/0x0d/0x0e.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
           (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  // Byte 4c+r sits at bits [127-8*(4c+r) -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gf_mul(a[r], 4'he) ^ gf_mul(a[(r+1)%4], 4'hb) ^
                                gf_mul(a[(r+2)%4], 4'hd) ^ gf_mul(a[(r+3)%4], 4'h9);
    end
    return o;
  endfunction

  for (genvar gi = 0; gi < 16; gi++) begin : g_rk
    if (gi <= 10) begin : g_valid
      assign w_rk_arr[gi] = key[1407-128*gi -: 128];
    end else begin : g_unused
      assign w_rk_arr[gi] = '0;
    end
  end

  for (genvar gb = 0; gb < 16; gb++) begin : g_isb
    aes_inv_sbox u_inv_sbox (
      .i_a (w_isr[127-8*gb -: 8]),
      .o_y (w_isb[127-8*gb -: 8])
    );
  end

  // cnt reaches 0 in FINAL, so the same mux serves both the rounds and the last key.
  assign w_rk10 = key[127:0];
  assign w_isr  = inv_shift_rows(r_state);
  assign w_rk   = w_rk_arr[r_cnt];
  assign w_ark  = w_isb ^ w_rk;
  assign w_imc  = inv_mix_columns(w_ark);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_cnt   <= 4'd0;
      r_state <= '0;
      r_plain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (start) begin
            r_state <= cipher_data ^ w_rk10;
            r_cnt   <= 4'd9;
            r_busy  <= 1'b1;
            r_fsm   <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_state <= w_imc;
          r_cnt   <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_fsm <= S_FINAL;
        end
        S_FINAL: begin
          r_plain <= w_ark;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_fsm   <= S_IDLE;
        end
        default: begin
          r_busy <= 1'b0;
          r_fsm  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign plain_data = r_plain;
endmodule
